// File: rtl/phase_accumulator.sv
// phase_accumulator: numerically controlled phase generator feeding the dds
// phase input. One output phase is produced per ce cycle. Each sample is the
// accumulator plus a phase offset, with optional LFSR dither below the
// truncation point, truncated to PHASE_DW.
//
// Ports:
//   clk                  clock
//   reset                synchronous reset, active-high
//   ce                   sample strobe, one output phase per ce cycle
//   sync                 clears the accumulator (phase restart)
//   s_axis_cfg_tdata     {phase_offset, freq_word}, each ACC_DW bits
//   s_axis_cfg_tvalid    config valid
//   s_axis_cfg_tready    config ready
//   m_axis_phase_tdata   unsigned phase, full scale = 2*pi
//   m_axis_phase_tvalid  phase valid (no backpressure)
module phase_accumulator #(
    parameter int ACC_DW    = 32,
    parameter int PHASE_DW  = 16,
    parameter int DITHER    = 0,
    parameter int DITHER_DW = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  sync,
    input  logic [2*ACC_DW-1:0]   s_axis_cfg_tdata,
    input  logic                  s_axis_cfg_tvalid,
    output logic                  s_axis_cfg_tready,
    output logic [PHASE_DW-1:0]   m_axis_phase_tdata,
    output logic                  m_axis_phase_tvalid
);

    logic [ACC_DW-1:0] acc;
    logic [ACC_DW-1:0] freq_reg;
    logic [ACC_DW-1:0] offset_reg;
    logic [ACC_DW-1:0] freq_shadow;
    logic [ACC_DW-1:0] offset_shadow;
    logic              pending;
    logic              reset_state;
    logic [15:0]       lfsr;

    logic [ACC_DW-1:0] eff_freq;
    logic [ACC_DW-1:0] eff_offset;
    logic [ACC_DW-1:0] base;
    logic [ACC_DW-1:0] dither;
    logic [ACC_DW-1:0] sum;
    logic              lfsr_fb;
    logic              cfg_fire;
    // Bits below the truncation point only matter through their carry.
    logic              sum_low_unused;

    assign s_axis_cfg_tready = !reset_state && !pending;
    assign cfg_fire          = s_axis_cfg_tvalid && s_axis_cfg_tready;
    assign sum_low_unused    = ^sum[ACC_DW-PHASE_DW-1:0];

    always_comb begin
        // A pending config takes effect on the very ce cycle that applies it.
        eff_freq   = pending ? freq_shadow   : freq_reg;
        eff_offset = pending ? offset_shadow : offset_reg;
        base       = sync ? '0 : acc;
        dither     = '0;
        if (DITHER != 0) begin
            dither[DITHER_DW-1:0] = lfsr[DITHER_DW-1:0];
        end
        sum     = base + eff_offset + dither;
        // x^16 + x^14 + x^13 + x^11 + 1, shifting left into bit 0
        lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc                 <= '0;
            freq_reg            <= '0;
            offset_reg          <= '0;
            freq_shadow         <= '0;
            offset_shadow       <= '0;
            pending             <= 1'b0;
            reset_state         <= 1'b1;
            lfsr                <= 16'hACE1;
            m_axis_phase_tdata  <= '0;
            m_axis_phase_tvalid <= 1'b0;
        end else begin
            reset_state <= 1'b0;
            // tready is low while pending, so a capture never coincides
            // with the ce that retires a pending config.
            if (cfg_fire) begin
                offset_shadow <= s_axis_cfg_tdata[2*ACC_DW-1:ACC_DW];
                freq_shadow   <= s_axis_cfg_tdata[ACC_DW-1:0];
                pending       <= 1'b1;
            end
            if (ce) begin
                m_axis_phase_tdata  <= sum[ACC_DW-1 -: PHASE_DW];
                m_axis_phase_tvalid <= 1'b1;
                acc                 <= base + eff_freq;
                if (pending) begin
                    freq_reg   <= freq_shadow;
                    offset_reg <= offset_shadow;
                    pending    <= 1'b0;
                end
                if (DITHER != 0) begin
                    lfsr <= {lfsr[14:0], lfsr_fb};
                end
            end else begin
                m_axis_phase_tvalid <= 1'b0;
                if (sync) begin
                    acc <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_phase_accumulator.sv
// tb_phase_accumulator: directed test of phase_accumulator with hand-computed
// expected phases. A second instance with dither enabled shares the stimulus
// and is checked for dither staying below the truncation point.
module tb_phase_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        sync;
    logic [63:0] cfg_tdata;
    logic        cfg_tvalid;
    logic        cfg_tready;
    logic [15:0] phase_tdata;
    logic        phase_tvalid;
    logic        d_cfg_tready;
    logic [15:0] d_phase_tdata;
    logic        d_phase_tvalid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    phase_accumulator #(
        .ACC_DW(32), .PHASE_DW(16), .DITHER(0), .DITHER_DW(4)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .sync(sync),
        .s_axis_cfg_tdata(cfg_tdata), .s_axis_cfg_tvalid(cfg_tvalid),
        .s_axis_cfg_tready(cfg_tready),
        .m_axis_phase_tdata(phase_tdata), .m_axis_phase_tvalid(phase_tvalid)
    );

    phase_accumulator #(
        .ACC_DW(32), .PHASE_DW(16), .DITHER(1), .DITHER_DW(4)
    ) dut_dither (
        .clk(clk), .reset(reset), .ce(ce), .sync(sync),
        .s_axis_cfg_tdata(cfg_tdata), .s_axis_cfg_tvalid(cfg_tvalid),
        .s_axis_cfg_tready(d_cfg_tready),
        .m_axis_phase_tdata(d_phase_tdata), .m_axis_phase_tvalid(d_phase_tvalid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one config word and hold it for one handshake edge.
    task automatic send_cfg(input logic [31:0] off, input logic [31:0] freq);
        for (int i = 0; i < 20 && !cfg_tready; i++) tick();
        chk("cfg_ready_wait", {31'd0, cfg_tready}, 32'd1);
        cfg_tdata  = {off, freq};
        cfg_tvalid = 1'b1;
        tick();
        cfg_tvalid = 1'b0;
    endtask

    task automatic chk_phase(input string tag, input logic [15:0] exp);
        chk(tag, {16'd0, phase_tdata}, {16'd0, exp});
        chk({tag, "_valid"}, {31'd0, phase_tvalid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ce = 1'b0; sync = 1'b0;
        cfg_tdata = '0; cfg_tvalid = 1'b0;
        tick();
        chk("rst_tdata",  {16'd0, phase_tdata}, 32'd0);
        chk("rst_tvalid", {31'd0, phase_tvalid}, 32'd0);
        chk("rst_tready", {31'd0, cfg_tready}, 32'd0);
        tick();
        chk("rst_tready_held", {31'd0, cfg_tready}, 32'd0);
        reset = 1'b0;
        tick();
        chk("tready_after_rst", {31'd0, cfg_tready}, 32'd1);

        // Basic ramp
        send_cfg(32'h0000_0000, 32'h0100_0000);
        chk("tready_pending", {31'd0, cfg_tready}, 32'd0);
        ce = 1'b1;
        tick(); chk_phase("ramp0", 16'h0000);
        chk("tready_after_ce", {31'd0, cfg_tready}, 32'd1);
        tick(); chk_phase("ramp1", 16'h0100);
        tick(); chk_phase("ramp2", 16'h0200);
        tick(); chk_phase("ramp3", 16'h0300);

        // Wrap-around, restarted by sync coinciding with a pending config
        ce = 1'b0;
        send_cfg(32'h0000_0000, 32'h4000_0000);
        chk("ce0_tvalid", {31'd0, phase_tvalid}, 32'd0);
        chk("ce0_hold",   {16'd0, phase_tdata}, 32'h0300);
        ce = 1'b1; sync = 1'b1;
        tick(); chk_phase("wrap0", 16'h0000);
        sync = 1'b0;
        tick(); chk_phase("wrap1", 16'h4000);
        tick(); chk_phase("wrap2", 16'h8000);
        tick(); chk_phase("wrap3", 16'hC000);
        tick(); chk_phase("wrap4", 16'h0000);

        // Offsets
        ce = 1'b0;
        send_cfg(32'h4000_0000, 32'h0100_0000);
        ce = 1'b1; sync = 1'b1;
        tick(); chk_phase("off0", 16'h4000);
        sync = 1'b0;
        tick(); chk_phase("off1", 16'h4100);
        tick(); chk_phase("off2", 16'h4200);
        ce = 1'b0;
        send_cfg(32'hFF00_0000, 32'h0100_0000);
        ce = 1'b1; sync = 1'b1;
        tick(); chk_phase("offwrap0", 16'hFF00);
        sync = 1'b0;
        tick(); chk_phase("offwrap1", 16'h0000);
        tick(); chk_phase("offwrap2", 16'h0100);
        // acc is now 0x0300_0000

        // Config stall: second word held off until the first is applied
        ce = 1'b0;
        cfg_tdata = {32'h2000_0000, 32'h0200_0000}; cfg_tvalid = 1'b1;
        tick();
        chk("stall_tready0", {31'd0, cfg_tready}, 32'd0);
        cfg_tdata = {32'h1000_0000, 32'h0080_0000};
        tick();
        chk("stall_tready1", {31'd0, cfg_tready}, 32'd0);
        chk("stall_tvalid",  {31'd0, phase_tvalid}, 32'd0);
        ce = 1'b1;
        tick(); chk_phase("stall_apply", 16'h2300);   // 0x0300_0000 + 0x2000_0000
        chk("stall_tready2", {31'd0, cfg_tready}, 32'd1);
        ce = 1'b0;
        tick();
        cfg_tvalid = 1'b0;
        chk("stall_accept", {31'd0, cfg_tready}, 32'd0);
        ce = 1'b1;
        tick(); chk_phase("second0", 16'h1500);       // 0x0500_0000 + 0x1000_0000
        tick(); chk_phase("second1", 16'h1580);       // 0x0580_0000 + 0x1000_0000

        // Sync mid-stream
        ce = 1'b0;
        send_cfg(32'h0000_0000, 32'h0100_0000);
        ce = 1'b1; sync = 1'b1;
        tick(); chk_phase("sync_pre0", 16'h0000);
        sync = 1'b0;
        tick(); tick(); tick(); tick();
        tick(); chk_phase("sync_pre5", 16'h0500);
        sync = 1'b1;
        tick(); chk_phase("sync_ce0", 16'h0000);
        sync = 1'b0;
        tick(); chk_phase("sync_ce1", 16'h0100);
        tick(); chk_phase("sync_ce2", 16'h0200);
        ce = 1'b0; sync = 1'b1;
        tick();
        chk("sync_idle_tvalid", {31'd0, phase_tvalid}, 32'd0);
        sync = 1'b0; ce = 1'b1;
        tick(); chk_phase("sync_idle0", 16'h0000);
        tick(); chk_phase("sync_idle1", 16'h0100);

        // Reset mid-stream
        reset = 1'b1;
        tick();
        chk("mid_rst_tvalid", {31'd0, phase_tvalid}, 32'd0);
        chk("mid_rst_tdata",  {16'd0, phase_tdata}, 32'd0);
        chk("mid_rst_tready", {31'd0, cfg_tready}, 32'd0);
        reset = 1'b0; ce = 1'b0;
        tick();
        send_cfg(32'h4000_0000, 32'h0100_0000);
        ce = 1'b1;
        tick(); chk_phase("restart0", 16'h4000);
        tick(); chk_phase("restart1", 16'h4100);

        // Dither must never reach the truncated output
        ce = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        send_cfg(32'h0000_0000, 32'h0000_0000);
        ce = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("dither_zero", {16'd0, d_phase_tdata}, 32'd0);
            chk("dither_valid", {31'd0, d_phase_tvalid}, 32'd1);
        end
        ce = 1'b0;
        for (int i = 0; i < 20 && !d_cfg_tready; i++) tick();
        chk("dither_ready", {31'd0, d_cfg_tready}, 32'd1);
        send_cfg(32'h0000_0000, 32'h0100_0000);
        ce = 1'b1; sync = 1'b1;
        tick();
        chk("dither_ramp0", {16'd0, d_phase_tdata}, 32'h0000);
        sync = 1'b0;
        tick();
        chk("dither_ramp1", {16'd0, d_phase_tdata}, 32'h0100);
        tick();
        chk("dither_ramp2", {16'd0, d_phase_tdata}, 32'h0200);
        ce = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
